// File: rtl/host_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : host_cmd_pkg
// Description : Shared FSM state type, decoder command codes and response
//               codes for the host UART command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package host_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_LO  = 3'd3,
    ST_WAIT_HI  = 3'd4,
    ST_DISPATCH = 3'd5,
    ST_YAW_WAIT = 3'd6,
    ST_RESP     = 3'd7
  } state_t;

  localparam logic [15:0] CMD_ENC_OFF = 16'h0001;
  localparam logic [15:0] CMD_ENC_ON  = 16'h0002;
  localparam logic [15:0] CMD_YAW     = 16'h0003;
  localparam logic [15:0] CMD_ERR     = 16'hFFFF;

  localparam logic [7:0] RESP_ACK     = 8'h00;
  localparam logic [7:0] RESP_DEC_ERR = 8'hEE;
  localparam logic [7:0] RESP_DEC_TO  = 8'hE1;
  localparam logic [7:0] RESP_YAW_TO  = 8'hE2;

endpackage
`default_nettype wire

// File: rtl/host_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : host_frame_assembler
// Description : Packs UART bytes into a frame (byte i at [8i+7:8i]), tracks
//               the byte count and RX silence, and flags when the frame closes.
// Revision    : 1.0 - initial release
// ============================================================================
module host_frame_assembler #(
  parameter int FRAME_BYTES  = 128,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     first_byte,
  input  logic                     collect,
  output logic [FRAME_BYTES*8-1:0] frame,
  output logic                     frame_ready
);

  localparam int BC_W = $clog2(FRAME_BYTES + 1);
  localparam int IT_W = $clog2(IDLE_TIMEOUT);
  localparam int FW_W = $clog2(FRAME_BYTES * 8);

  logic [BC_W-1:0] byte_cnt;
  logic [IT_W-1:0] idle_cnt;
  logic [FW_W-1:0] wr_pos;

  assign wr_pos = FW_W'(byte_cnt) * FW_W'(8);

  // Closing is decided in the same cycle as the last byte so the top can
  // issue dec_start on the very next cycle; a byte arrival resets idle time.
  assign frame_ready = collect &&
                       (rx_valid ? (byte_cnt == BC_W'(FRAME_BYTES - 1))
                                 : (idle_cnt == IT_W'(IDLE_TIMEOUT - 1)));

  // Byte packing, byte count and RX-silence counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame    <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else if (first_byte) begin
      frame    <= {{(FRAME_BYTES*8-8){1'b0}}, rx_data};
      byte_cnt <= BC_W'(1);
      idle_cnt <= '0;
    end else if (collect) begin
      if (rx_valid) begin
        frame[wr_pos +: 8] <= rx_data;
        byte_cnt           <= byte_cnt + 1'b1;
        idle_cnt           <= '0;
      end else if (idle_cnt != IT_W'(IDLE_TIMEOUT - 1)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/host_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : host_cmd_sequencer
// Description : Host UART command path sequencer: frame assembly, decoder
//               handshake, command dispatch, yaw request and response.
// Revision    : 1.0 - initial release
// ============================================================================
module host_cmd_sequencer
  import host_cmd_pkg::*;
#(
  parameter int FRAME_BYTES  = 128,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int DEC_TIMEOUT  = 16,
  parameter int YAW_TIMEOUT  = 100000,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [1023:0]    dec_frame,
  output logic             dec_start,
  input  logic             dec_done,
  input  logic             dec_error,
  input  logic [15:0]      dec_cmd_select,
  input  logic [255:0]     dec_output,
  output logic             encrypt_en,
  output logic             yaw_req,
  output logic [47:0]      yaw_target,
  input  logic             yaw_ack,
  output logic             resp_valid,
  output logic [7:0]       resp_code,
  input  logic             resp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int DT_W = $clog2(DEC_TIMEOUT);
  localparam int YT_W = $clog2(YAW_TIMEOUT);

  state_t          state, state_nxt;
  logic [DT_W-1:0] dec_tmr;
  logic [YT_W-1:0] yaw_tmr;
  logic            frame_ready, dec_to, yaw_to;
  logic            resp_load, enc_load, enc_nxt, yaw_set, yaw_clr;
  logic [7:0]      resp_nxt;

  host_frame_assembler #(
    .FRAME_BYTES  (FRAME_BYTES),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_asm (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .first_byte  ((state == ST_IDLE) && rx_valid),
    .collect     (state == ST_COLLECT),
    .frame       (dec_frame),
    .frame_ready (frame_ready)
  );

  assign dec_start  = (state == ST_START);
  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign dec_to     = (dec_tmr == DT_W'(DEC_TIMEOUT - 1));
  assign yaw_to     = (yaw_tmr == YT_W'(YAW_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and action decode.
  always_comb begin
    state_nxt = state;
    resp_load = 1'b0;
    resp_nxt  = RESP_ACK;
    enc_load  = 1'b0;
    enc_nxt   = encrypt_en;
    yaw_set   = 1'b0;
    yaw_clr   = 1'b0;
    case (state)
      ST_IDLE:    if (rx_valid) state_nxt = ST_COLLECT;
      ST_COLLECT: if (frame_ready) state_nxt = ST_START;
      ST_START:   state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!dec_done) state_nxt = ST_WAIT_HI;
        else if (dec_to) begin
          resp_load = 1'b1;
          resp_nxt  = RESP_DEC_TO;
          state_nxt = ST_RESP;
        end
      end
      ST_WAIT_HI: begin
        if (dec_done) state_nxt = ST_DISPATCH;
        else if (dec_to) begin
          resp_load = 1'b1;
          resp_nxt  = RESP_DEC_TO;
          state_nxt = ST_RESP;
        end
      end
      ST_DISPATCH: begin
        resp_load = 1'b1;
        state_nxt = ST_RESP;
        if (dec_error || (dec_cmd_select == CMD_ERR)) begin
          resp_nxt = RESP_DEC_ERR;
        end else if (dec_cmd_select == CMD_ENC_OFF) begin
          enc_load = 1'b1;
          enc_nxt  = 1'b0;
        end else if (dec_cmd_select == CMD_ENC_ON) begin
          enc_load = 1'b1;
          enc_nxt  = 1'b1;
        end else if (dec_cmd_select == CMD_YAW) begin
          resp_load = 1'b0;
          yaw_set   = 1'b1;
          state_nxt = ST_YAW_WAIT;
        end else begin
          resp_nxt = RESP_DEC_ERR;
        end
      end
      ST_YAW_WAIT: begin
        // An ack coinciding with the timeout still counts as success.
        if (yaw_ack) begin
          yaw_clr   = 1'b1;
          resp_load = 1'b1;
          state_nxt = ST_RESP;
        end else if (yaw_to) begin
          yaw_clr   = 1'b1;
          resp_load = 1'b1;
          resp_nxt  = RESP_YAW_TO;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP:    if (resp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Decoder and yaw timers; both saturate so a late state change cannot wrap them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_tmr <= '0;
      yaw_tmr <= '0;
    end else begin
      if (state == ST_START) dec_tmr <= '0;
      else if (((state == ST_WAIT_LO) || (state == ST_WAIT_HI)) && !dec_to)
        dec_tmr <= dec_tmr + 1'b1;
      if (state == ST_DISPATCH) yaw_tmr <= '0;
      else if ((state == ST_YAW_WAIT) && !yaw_to) yaw_tmr <= yaw_tmr + 1'b1;
    end
  end

  // Action registers: encryption enable, yaw request/target, response code.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      encrypt_en <= 1'b0;
      yaw_req    <= 1'b0;
      yaw_target <= '0;
      resp_code  <= '0;
    end else begin
      if (enc_load)  encrypt_en <= enc_nxt;
      if (resp_load) resp_code  <= resp_nxt;
      if (yaw_set) begin
        yaw_req    <= 1'b1;
        yaw_target <= dec_output[47:0];
      end else if (yaw_clr) begin
        yaw_req <= 1'b0;
      end
    end
  end

  // Saturating error and drop counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count  <= '0;
      drop_count <= '0;
    end else begin
      if ((state == ST_RESP) && resp_ready && (resp_code != RESP_ACK) && (err_count != '1))
        err_count <= err_count + 1'b1;
      if (rx_valid && (state != ST_IDLE) && (state != ST_COLLECT) && (drop_count != '1))
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule
`default_nettype wire
